uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART_tx serializer among NUM_REQ byte requesters. Round-robin
//  grant, latches the winner's byte, pulses UART_tx start, waits for done_flag
//  and then acks the winner. A watchdog aborts a frame whose done never arrives.
//  Sits between the client blocks and the single UART_tx instance.
// PARAMETERS
//  NUM_REQ     4       number of requesters (2..16)
//  DATA_W      8       byte width, matches UART_tx tx_data
//  TIMEOUT_CYC 200000  max clk cycles from tx_start to tx_done before abort
// PORTS
//  clk        in   1                 system clock, rising edge
//  rst        in   1                 async reset, ACTIVE-LOW (0 = reset)
//  req        in   NUM_REQ           req[i]=1: requester i holds a byte pending
//  req_data   in   NUM_REQ*DATA_W    byte of req i at [i*DATA_W +: DATA_W]
//  ack        out  NUM_REQ           1-cycle pulse: byte of req i sent
//  err        out  NUM_REQ           1-cycle pulse: req i frame timed out
//  tx_data    out  DATA_W            to UART_tx tx_data; stable from start to done
//  tx_start   out  1                 to UART_tx start; 1-cycle pulse per frame
//  tx_done    in   1                 from UART_tx done_flag; 1-cycle pulse
//  busy       out  1                 1 when state != IDLE
//  grant_id   out  clog2(NUM_REQ)    index of current/last granted requester
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; ack=0, err=0, tx_start=0, tx_data=0,
//   busy=0, grant_id=0, rr_ptr=NUM_REQ-1 (so req 0 wins first), timer=0.
//  FSM IDLE -> LOAD -> WAIT -> IDLE:
//   IDLE: if |req: winner = first set bit scanning rr_ptr+1, rr_ptr+2, ...
//    wrapping mod NUM_REQ; latch req_data[winner] into tx_data,
//    grant_id<=winner, go LOAD. No req: stay.
//   LOAD: tx_start=1 for exactly this cycle; timer cleared; go WAIT.
//   WAIT: timer increments each cycle. tx_done=1 -> ack[grant_id] pulses next
//    cycle (registered), rr_ptr<=grant_id, go IDLE. timer reaches
//    TIMEOUT_CYC-1 with no tx_done -> err[grant_id] pulse next cycle,
//    rr_ptr<=grant_id, go IDLE. tx_done and timeout same cycle: done wins.
//  Latency: req rising in IDLE -> tx_start 2 cycles later (IDLE, LOAD).
//   tx_done -> ack 1 cycle; earliest next tx_start 2 cycles after ack state.
//  Handshake: requester holds req and req_data until ack or err; it may drop
//   req only after that pulse. req dropped during LOAD/WAIT: frame completes,
//   ack still issued. req_data changes after grant are ignored (latched).
//  Fairness: a requester that just completed has lowest priority next round;
//   with all reqs held continuously grants cycle 0,1,..,NUM_REQ-1,0,...
//  tx_done outside WAIT (incl. LOAD) ignored. At most one ack/err bit set per
//   cycle; ack and err never both set.
//  tx_data holds its value after frame end until next IDLE->LOAD latch.
//  Reset mid-frame: immediate return to reset values; no ack/err for the
//   interrupted frame; UART_tx is reset by the same rst.
//  timer width clog2(TIMEOUT_CYC); no wrap, saturates at terminal value.
// TESTING
//  1 Single req: req[2]=1, data 8'h29 -> tx_start 2 cycles later, tx_data=8'h29
//    until tx_done; ack=4'b0100 one cycle after tx_done; busy 0 after.
//  2 Round robin: all req held, data i=8'hA0+i -> tx_data order A0,A1,A2,A3,A0;
//    exactly one ack per frame, matching grant_id.
//  3 Fairness after reset: req=4'b1001 -> req 0 first, then 3, then 0.
//  4 Timeout (TIMEOUT_CYC=50, tx_done stuck 0): err[grant_id] pulse 50 cycles
//    after tx_start, no ack, next req granted normally.
//  5 Spurious tx_done in IDLE/LOAD -> no ack, FSM unaffected; done+timeout
//    same cycle -> ack only.
//  6 rst=0 mid-WAIT -> all outputs 0 asynchronously, rr_ptr reset; after
//    release req 0 granted first, no stale ack.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters,
// with a per-frame watchdog that aborts a frame whose done pulse never arrives.
//
//   state | meaning
//   IDLE  | no frame in flight; pick next requester round-robin
//   LOAD  | byte latched; raise tx_start for one cycle, clear timer
//   WAIT  | frame on the wire; wait for tx_done or watchdog expiry
module uart_tx_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_W      = 8,
  parameter  int TIMEOUT_CYC = 200000,
  localparam int GW          = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [GW-1:0]             grant_id
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_TERM = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [GW-1:0]       r_rr_ptr;
  logic [GW-1:0]       r_grant_id;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_tx_start;
  logic [NUM_REQ-1:0]  r_ack;
  logic [NUM_REQ-1:0]  r_err;
  logic [TW-1:0]       r_timer;

  logic                w_found;
  logic [GW-1:0]       w_winner;
  logic [GW-1:0]       w_idx;
  logic [DATA_W-1:0]   w_win_data;
  logic [NUM_REQ-1:0]  w_grant_oh;

  // Scan starts just past the last completed requester so it ranks lowest.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = GW'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_win_data = req_data[int'(w_winner)*DATA_W +: DATA_W];
  assign w_grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= GW'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_ack      <= '0;
      r_err      <= '0;
      r_timer    <= '0;
    end else begin
      r_tx_start <= 1'b0;
      r_ack      <= '0;
      r_err      <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_tx_data  <= w_win_data;
            r_grant_id <= w_winner;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_tx_start <= 1'b1;
          r_timer    <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the terminal cycle still counts as success.
          if (tx_done) begin
            r_ack    <= w_grant_oh;
            r_rr_ptr <= r_grant_id;
            r_state  <= ST_IDLE;
          end else if (r_timer == TIMER_TERM) begin
            r_err    <= w_grant_oh;
            r_rr_ptr <= r_grant_id;
            r_state  <= ST_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack      = r_ack;
  assign err      = r_err;
  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign busy     = (r_state != ST_IDLE);
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected start/ack/err
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 50;
  localparam int K_START = 0;
  localparam int K_ACK   = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int kind;
    int id;
    int data;
    int dly;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   ack;
  logic [NR-1:0]   err;
  logic [DW-1:0]   tx_data;
  logic            tx_start;
  logic            tx_done;
  logic            busy;
  logic [1:0]      grant_id;

  logic model_done = 1'b0;
  logic force_done = 1'b0;
  assign tx_done = model_done | force_done;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   cnt_left[NR] = '{0, 0, 0, 0};
  int   done_delay = 10;
  bit   done_en = 1'b1;
  int   last_start_cyc = 0;
  int   last_data = 0;
  int   req_cyc = 0;
  exp_t exp_q[$];
  exp_t me;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .err      (err),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push_frame(input int id, input int data, input int kind_end, input int dly);
    exp_q.push_back('{kind: K_START, id: id, data: data, dly: -1});
    exp_q.push_back('{kind: kind_end, id: id, data: data, dly: dly});
  endtask

  // Requesters hold req until their ack/err pulse, one frame per count.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NR; i++) begin
      if ((ack[i] || err[i]) && cnt_left[i] > 0) cnt_left[i]--;
      req[i] = (cnt_left[i] > 0);
    end
  end

  // UART model: done pulse done_delay cycles after tx_start; aborted by reset.
  initial begin
    bit ok;
    forever begin
      @(negedge clk);
      if (rst && tx_start && done_en) begin
        ok = 1'b1;
        for (int i = 0; i < done_delay; i++) begin
          @(posedge clk);
          if (!rst) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          #1 model_done = 1'b1;
          @(posedge clk);
          #1 model_done = 1'b0;
        end
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_start: got start grant %0d data %0h, expected none", grant_id, tx_data);
        end else begin
          me = exp_q.pop_front();
          chk("start_kind", K_START, me.kind);
          chk("start_grant", int'(grant_id), me.id);
          chk("start_data", int'(tx_data), me.data);
          last_start_cyc = cyc;
          last_data = me.data;
        end
      end
      if (ack != 0 || err != 0) begin
        chk("ack_err_exclusive", int'(ack != 0 && err != 0), 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_end: got ack %b err %b, expected none", ack, err);
        end else begin
          me = exp_q.pop_front();
          chk("end_kind", (ack != 0) ? K_ACK : K_ERR, me.kind);
          chk("end_vector", int'(ack | err), 1 << me.id);
          chk("end_latency", cyc - last_start_cyc, me.dly);
          if (ack != 0) chk("tx_data_hold", int'(tx_data), last_data);
        end
      end
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while ((cnt_left[0] + cnt_left[1] + cnt_left[2] + cnt_left[3] != 0 ||
            exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_budget: got %0d pending events after %0d cycles, expected 0", exp_q.size(), n);
    end
    @(posedge clk);
    #1;
    chk("busy_after", int'(busy), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ack"}, int'(ack), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_tx_start"}, int'(tx_start), 0);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_grant_id"}, int'(grant_id), 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // 1: single requester, latency, data latched against later changes
    repeat (2) @(posedge clk);
    #1;
    req_data[2*DW +: DW] = 8'h29;
    push_frame(2, 'h29, K_ACK, 11);
    cnt_left[2] = 1;
    req_cyc = cyc;
    repeat (4) @(posedge clk);
    #1 req_data[2*DW +: DW] = 8'hFF;
    wait_done(200);
    chk("start_latency", last_start_cyc - req_cyc, 2);

    // 2: round robin with all held
    reset_pulse();
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    push_frame(0, 'hA0, K_ACK, 11);
    push_frame(1, 'hA1, K_ACK, 11);
    push_frame(2, 'hA2, K_ACK, 11);
    push_frame(3, 'hA3, K_ACK, 11);
    push_frame(0, 'hA0, K_ACK, 11);
    cnt_left = '{2, 1, 1, 1};
    wait_done(400);

    // 3: fairness after reset with req 0 and 3
    reset_pulse();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    push_frame(0, 'h11, K_ACK, 11);
    push_frame(3, 'h44, K_ACK, 11);
    push_frame(0, 'h11, K_ACK, 11);
    cnt_left[0] = 2;
    cnt_left[3] = 1;
    wait_done(300);

    // 4: timeout then normal grant
    done_en = 1'b0;
    push_frame(1, 'h22, K_ERR, TO);
    cnt_left[1] = 1;
    wait_done(300);
    done_en = 1'b1;
    push_frame(2, 'h33, K_ACK, 11);
    cnt_left[2] = 1;
    wait_done(200);

    // 5: spurious done in IDLE and LOAD, then done on the timeout cycle
    @(posedge clk);
    #1 force_done = 1'b1;
    @(posedge clk);
    #1 force_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("idle_spurious_busy", int'(busy), 0);
    done_delay = 5;
    push_frame(3, 'h44, K_ACK, 6);
    @(posedge clk);
    #1 cnt_left[3] = 1;
    @(posedge clk);
    #1 force_done = 1'b1;
    @(posedge clk);
    #1 force_done = 1'b0;
    wait_done(200);
    done_delay = TO - 1;
    push_frame(0, 'h11, K_ACK, TO);
    cnt_left[0] = 1;
    wait_done(300);

    // 6: reset mid-WAIT
    done_delay = 10;
    push_frame(1, 'h22, K_ACK, 11);
    cnt_left[1] = 1;
    wait_done(200);
    done_delay = 30;
    push_frame(3, 'h44, K_ACK, 31);
    cnt_left[3] = 1;
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_zero_outputs("midframe_reset");
    cnt_left = '{0, 0, 0, 0};
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    done_delay = 10;
    push_frame(0, 'h11, K_ACK, 11);
    push_frame(2, 'h33, K_ACK, 11);
    cnt_left[0] = 1;
    cnt_left[2] = 1;
    wait_done(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion, expected finish before 500000");
    $fatal(1, "bench did not complete");
  end

endmodule
